sel_cmp_pipe: RTL and testbench

Parametrised, pipelined successor to the team's combinational word-select/compare logic. It accepts NCH candidate words of WIDTH bits, selects one per transaction, and applies one of four per-transaction operations: pass, unsigned compare against a reference, highest-set-bit index, or running accumulate. The block sits between the operand-select front end and downstream consumers. It uses valid/ready handshakes on both sides and has a fixed two-stage latency.

---
 rtl/sel_cmp_pipe.sv | 155 +++++++++++++++
 tb/tb_sel_cmp_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_cmp_pipe.sv
// sel_cmp_pipe: two-stage pipelined word select and operate block.
// Selects one of NCH candidate words per transaction and applies PASS,
// unsigned CMP against a reference, MSB index, or running ACC.
//
// Ports:
//   pclk, prst_n          clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data               NCH packed words, channel k at [k*WIDTH +: WIDTH]
//   in_sel                channel select (values >= NCH flag a select error)
//   in_mode               0 PASS, 1 CMP, 2 MSB, 3 ACC
//   in_ref                CMP reference
//   out_valid/out_ready   output handshake
//   out_word/out_flag     result word and mode-dependent flag
//   out_idx               highest set bit index (MSB mode only)
//   sel_err_cnt           saturating count of accepted out-of-range selects
module sel_cmp_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int SELW  = $clog2(NCH),
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic                   pclk,
    input  logic                   prst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]        in_sel,
    input  logic [1:0]             in_mode,
    input  logic [WIDTH-1:0]       in_ref,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_word,
    output logic                   out_flag,
    output logic [IDXW-1:0]        out_idx,
    output logic [7:0]             sel_err_cnt
);

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_CMP  = 2'd1,
        MODE_MSB  = 2'd2,
        MODE_ACC  = 2'd3
    } mode_e;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_word;
    mode_e            r_s1_mode;
    logic [WIDTH-1:0] r_s1_ref;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out_word;
    logic             r_out_flag;
    logic [IDXW-1:0]  r_out_idx;
    logic [7:0]       r_err_cnt;

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_sel_err;
    logic [WIDTH-1:0] w_sel_word;
    logic [WIDTH:0]   w_sum;
    logic [IDXW-1:0]  w_msb;
    logic [WIDTH-1:0] w_res_word;
    logic             w_res_flag;
    logic [IDXW-1:0]  w_res_idx;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign w_sel_err = ({1'b0, in_sel} >= (SELW + 1)'(NCH));

    // Explicit channel match keeps out-of-range selects from indexing past in_data.
    always_comb begin
        w_sel_word = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (in_sel == SELW'(k)) begin
                w_sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        w_msb = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_s1_word[i]) begin
                w_msb = IDXW'(i);
            end
        end
    end

    assign w_sum = {1'b0, r_acc} + {1'b0, r_s1_word};

    always_comb begin
        w_res_word = r_s1_word;
        w_res_flag = 1'b0;
        w_res_idx  = '0;
        case (r_s1_mode)
            MODE_CMP: w_res_flag = (r_s1_word > r_s1_ref);
            MODE_MSB: begin
                w_res_idx  = w_msb;
                w_res_flag = |r_s1_word;
            end
            MODE_ACC: begin
                w_res_word = w_sum[WIDTH-1:0];
                w_res_flag = w_sum[WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_word  <= '0;
            r_s1_mode  <= MODE_PASS;
            r_s1_ref   <= '0;
            r_s2_valid <= 1'b0;
            r_acc      <= '0;
            r_out_word <= '0;
            r_out_flag <= 1'b0;
            r_out_idx  <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_word <= w_sel_err ? '0 : w_sel_word;
                    r_s1_mode <= mode_e'(in_mode);
                    r_s1_ref  <= in_ref;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_word <= w_res_word;
                    r_out_flag <= w_res_flag;
                    r_out_idx  <= w_res_idx;
                    if (r_s1_mode == MODE_ACC) begin
                        r_acc <= w_sum[WIDTH-1:0];
                    end
                end
            end
            if (in_valid && w_s1_adv && w_sel_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_word    = r_out_word;
    assign out_flag    = r_out_flag;
    assign out_idx     = r_out_idx;
    assign sel_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_sel_cmp_pipe.sv
module tb_sel_cmp_pipe;

    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 3;
    localparam int I = 3;

    logic           pclk;
    logic           prst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic [S-1:0]   in_sel;
    logic [1:0]     in_mode;
    logic [W-1:0]   in_ref;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_word;
    logic           out_flag;
    logic [I-1:0]   out_idx;
    logic [7:0]     sel_err_cnt;

    sel_cmp_pipe #(.WIDTH(W), .NCH(N), .SELW(S), .IDXW(I)) dut (
        .pclk(pclk), .prst_n(prst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_mode(in_mode), .in_ref(in_ref),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_flag(out_flag), .out_idx(out_idx),
        .sel_err_cnt(sel_err_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;

    // Reference state: expected results in order, accumulator, error count.
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int          m_acc  = 0;
    int          m_cnt  = 0;
    int          n_acc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pack(input int w, input int f, input int ix);
        return {8'(w), 1'(f), 3'(ix)};
    endfunction

    // Compare process: checks the output and counter every cycle against the model.
    always @(negedge pclk) begin
        if (!prst_n) begin
            exp_q.delete();
            m_acc = 0;
            m_cnt = 0;
            chk("rst_out_valid", 32'(out_valid), 0);
        end else begin
            chk("sel_err_cnt", 32'(sel_err_cnt), 32'(m_cnt));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 0);
                end else begin
                    chk("result", 32'({out_word, out_flag, out_idx}), 32'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        obs_q.push_back({out_word, out_flag, out_idx});
                    end
                end
            end
            if (in_valid && in_ready) begin
                int s, w, r, sum;
                s = int'(in_sel);
                w = (s < N) ? int'(in_data[s*W +: W]) : 0;
                r = int'(in_ref);
                n_acc++;
                if (s >= N && m_cnt < 255) m_cnt++;
                case (in_mode)
                    2'd0: exp_q.push_back(pack(w, 0, 0));
                    2'd1: exp_q.push_back(pack(w, (w > r) ? 1 : 0, 0));
                    2'd2: exp_q.push_back(pack(w, (w != 0) ? 1 : 0, (w != 0) ? $clog2(w + 1) - 1 : 0));
                    default: begin
                        sum = m_acc + w;
                        exp_q.push_back(pack(sum % 256, (sum > 255) ? 1 : 0, 0));
                        m_acc = sum % 256;
                    end
                endcase
            end
        end
    end

    task automatic send(input int sel, input int mode, input int word, input int rf);
        logic ok;
        in_data = {$urandom, $urandom};
        if (sel < N) in_data[sel*W +: W] = W'(word);
        in_sel   = S'(sel);
        in_mode  = 2'(mode);
        in_ref   = W'(rf);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge pclk) ok = in_ready;
            @(posedge pclk);
            #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    logic [11:0] lit[13];
    bit          rnd_done;

    initial begin
        prst_n    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_mode   = '0;
        in_ref    = '0;
        out_ready = 1'b1;
        cycles(3);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_word", 32'(out_word), 0);
        chk("rst_flag", 32'(out_flag), 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_cnt", 32'(sel_err_cnt), 0);
        @(negedge pclk) prst_n = 1'b1;
        cycles(1);
        chk("ready_after_rst", 32'(in_ready), 1);

        // PASS beat and its latency
        send(2, 0, 8'h5A, 0);
        chk("lat_not_yet", 32'(out_valid), 0);
        cycles(1);
        chk("lat_valid", 32'(out_valid), 1);
        chk("pass_word", 32'({out_word, out_flag, out_idx}), 32'(pack(8'h5A, 0, 0)));
        cycles(2);

        // CMP, MSB, chained ACC beats back to back
        obs_q.delete();
        send(1, 1, 8'h41, 8'h40);
        send(3, 1, 8'h40, 8'h40);
        send(0, 1, 8'h00, 8'h40);
        send(2, 2, 8'h01, 0);
        send(2, 2, 8'h80, 0);
        send(2, 2, 8'h00, 0);
        send(1, 3, 8'hF0, 0);
        send(1, 3, 8'h20, 0);
        send(1, 3, 8'h05, 0);
        send(0, 3, 8'h00, 0);
        cycles(4);
        lit = '{pack(8'h41,1,0), pack(8'h40,0,0), pack(8'h00,0,0),
                pack(8'h01,1,0), pack(8'h80,1,7), pack(8'h00,0,0),
                pack(8'hF0,0,0), pack(8'h10,1,0), pack(8'h15,0,0),
                pack(8'h15,0,0), 12'h0, 12'h0, 12'h0};
        chk("dir_count", 32'(obs_q.size()), 10);
        for (int i = 0; i < 10 && i < obs_q.size(); i++) chk($sformatf("dir_beat%0d", i), 32'(obs_q[i]), 32'(lit[i]));

        // Backpressure: 5 PASS beats with the output stalled for 4 cycles
        obs_q.delete();
        fork
            begin
                for (int i = 1; i <= 5; i++) send(i % N, 0, i, 0);
            end
            begin
                int base;
                out_ready = 1'b0;
                base = n_acc;
                cycles(4);
                chk("bp_accepts", 32'(n_acc - base), 2);
                chk("bp_ready_low", 32'(in_ready), 0);
                chk("bp_hold_word", 32'(out_word), 1);
                out_ready = 1'b1;
                #1;
                chk("bp_ready_same_cycle", 32'(in_ready), 1);
            end
        join
        cycles(4);
        chk("bp_count", 32'(obs_q.size()), 5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) chk($sformatf("bp_beat%0d", i), 32'(obs_q[i]), 32'(pack(i + 1, 0, 0)));

        // Random traffic with random output stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
                    if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 2));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    cycles(1);
                end
                out_ready = 1'b1;
            end
        join
        cycles(4);
        chk("rnd_drained", 32'(exp_q.size()), 0);

        // Out-of-range selects until the counter saturates
        for (int i = 0; i < 300; i++) send(5, $urandom_range(0, 3), $urandom_range(0, 255), 0);
        cycles(4);
        chk("cnt_saturated", 32'(sel_err_cnt), 255);

        // Reset with transactions in flight
        send(1, 3, 8'h33, 0);
        send(1, 3, 8'h33, 0);
        #2 prst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_cnt", 32'(sel_err_cnt), 0);
        cycles(2);
        @(negedge pclk) prst_n = 1'b1;
        cycles(1);
        obs_q.delete();
        send(0, 3, 8'h00, 0);
        cycles(3);
        chk("midrst_count", 32'(obs_q.size()), 1);
        if (obs_q.size() > 0) chk("midrst_acc_cleared", 32'(obs_q[0]), 32'(pack(0, 0, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
